// File: rtl/bin_bcd_conv.sv
// bin_bcd_conv: sequential double-dabble binary-to-BCD converter, one bit per cycle with valid/ready handshakes.
// Define BIN_BCD_SIGNED_EN to treat bin as two's complement (magnitude converted, sign on neg).
module bin_bcd_conv #(
  parameter int BIN_W  = 12,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf,
  output logic                  neg
);
  localparam int CW = $clog2(BIN_W + 1);
  localparam int BW = 4 * DIGITS;
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  state_t state, state_nx;
  logic [BIN_W-1:0] sh, mag;
  logic [BW-1:0] wr, adj;
  logic [CW-1:0] cnt;
  logic ovf_r, neg_r, sign, accept, last;
  genvar i;
  generate
    for (i = 0; i < DIGITS; i++) begin : g_adj
      assign adj[4*i+:4] = wr[4*i+:4] >= 4'd5 ? wr[4*i+:4] + 4'd3 : wr[4*i+:4];
    end
  endgenerate
`ifdef BIN_BCD_SIGNED_EN
  assign sign = bin[BIN_W-1];
  assign mag  = sign ? -bin : bin;
`else
  assign sign = 1'b0;
  assign mag  = bin;
`endif
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign accept    = in_valid && in_ready;
  assign last      = cnt == CW'(BIN_W - 1);
  assign bcd       = ovf_r ? {DIGITS{4'h9}} : wr;
  assign ovf       = ovf_r;
  assign neg       = neg_r;
  always_comb begin
    state_nx = state == IDLE ? (in_valid ? CONV : IDLE) :
               state == CONV ? (last ? DONE : CONV) :
               (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sh    <= '0;
      wr    <= '0;
      cnt   <= '0;
      ovf_r <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        sh    <= mag;
        wr    <= '0;
        cnt   <= '0;
        ovf_r <= 1'b0;
        neg_r <= sign;
      end else if (state == CONV) begin
        // a carry out of the top digit means the value does not fit
        wr    <= {adj[BW-2:0], sh[BIN_W-1]};
        sh    <= sh << 1;
        cnt   <= cnt + 1'b1;
        ovf_r <= ovf_r | adj[BW-1];
      end
    end
  end
endmodule

// File: tb/tb_bin_bcd_conv.sv
// tb_bin_bcd_conv: scoreboard bench for bin_bcd_conv (DIGITS=4 main instance, DIGITS=3 overflow instance).
module tb_bin_bcd_conv;
  typedef struct packed {
    logic [15:0] bcd;
    logic        ovf;
    logic        neg;
  } exp_t;
  logic clk = 0, reset = 1;
  logic in_valid = 0, out_ready = 0, in_ready, out_valid, ovf, neg;
  logic [11:0] bin = 0;
  logic [15:0] bcd;
  logic iv3 = 0, or3 = 0, ir3, ov3, ovf3, neg3;
  logic [11:0] b3 = 0, bcd3;
  int errors = 0, checks = 0;
  exp_t exp_q[$];
  always #5 clk = ~clk;
  bin_bcd_conv u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .bin(bin),
    .out_valid(out_valid), .out_ready(out_ready), .bcd(bcd), .ovf(ovf), .neg(neg)
  );
  bin_bcd_conv #(.BIN_W(12), .DIGITS(3)) u_dut3 (
    .clk(clk), .reset(reset), .in_valid(iv3), .in_ready(ir3), .bin(b3),
    .out_valid(ov3), .out_ready(or3), .bcd(bcd3), .ovf(ovf3), .neg(neg3)
  );
  function automatic exp_t model(input logic [11:0] v, input int d);
    exp_t e;
    int m = int'(v);
    int lim = 1;
    e.neg = 1'b0;
`ifdef BIN_BCD_SIGNED_EN
    if (v[11]) begin
      e.neg = 1'b1;
      m = 4096 - m;
    end
`endif
    for (int i = 0; i < d; i++) lim *= 10;
    e.ovf = m >= lim;
    e.bcd = '0;
    for (int i = 0; i < d; i++) begin
      e.bcd[4*i+:4] = e.ovf ? 4'd9 : 4'(m % 10);
      m /= 10;
    end
    return e;
  endfunction
  task automatic send(input logic [11:0] v);
    int n = 0;
    bin = v;
    in_valid = 1;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL send_ready: in_ready=%b want 1", in_ready);
    end
    exp_q.push_back(model(v, 4));
    @(posedge clk); #1;
    in_valid = 0;
  endtask
  task automatic receive(input int lat, input bit rel);
    int n = 0;
    exp_t e;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (!out_valid || n != lat) begin
      errors++;
      $display("FAIL latency: got %0d cycles (out_valid=%b) want %0d", n, out_valid, lat);
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got result bcd=%h with nothing expected", bcd);
    end else begin
      e = exp_q.pop_front();
      if ({bcd, ovf, neg} !== {e.bcd, e.ovf, e.neg}) begin
        errors++;
        $display("FAIL result: got bcd=%h ovf=%b neg=%b want bcd=%h ovf=%b neg=%b",
                 bcd, ovf, neg, e.bcd, e.ovf, e.neg);
      end
    end
    if (rel) begin
      out_ready = 1;
      @(posedge clk); #1;
      out_ready = 0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL release: got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
      end
    end
  endtask
  task automatic test_reset;
    reset = 1;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    checks++;
    if ({in_ready, out_valid, bcd, ovf, neg} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b vld=%b bcd=%h ovf=%b neg=%b want 1 0 0000 0 0",
               in_ready, out_valid, bcd, ovf, neg);
    end
  endtask
  task automatic test_convert;
    logic [11:0] vals [6] = '{12'd4095, 12'd0, 12'd9, 12'd1234, 12'hFFF, 12'h800};
    for (int i = 0; i < 6; i++) begin
      send(vals[i]);
      receive(12, 1);
    end
  endtask
  task automatic test_latch;
    send(12'd321);
    bin = 12'd999;
    receive(12, 1);
  endtask
  task automatic test_backpressure;
    logic [15:0] held;
    send(12'd4095);
    receive(12, 0);
    held = bcd;
    in_valid = 1;
    bin = 12'd7;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bcd !== held || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL backpressure: got bcd=%h rdy=%b vld=%b want %h 0 1", bcd, in_ready, out_valid, held);
      end
    end
    in_valid = 0;
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got in_ready=%b want 1", in_ready);
    end
    send(12'd7);
    receive(12, 1);
  endtask
  task automatic test_mid_reset;
    send(12'd1234);
    repeat (5) @(posedge clk);
    #1 reset = 1;
    @(posedge clk); #1;
    reset = 0;
    void'(exp_q.pop_back());
    checks++;
    if ({in_ready, out_valid, bcd, ovf} !== {1'b1, 1'b0, 16'h0, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset: got rdy=%b vld=%b bcd=%h ovf=%b want 1 0 0000 0", in_ready, out_valid, bcd, ovf);
    end
    send(12'd56);
    receive(12, 1);
  endtask
  task automatic test_back_to_back;
    int k = 0, got = 0, last = -1;
    bit acc;
    exp_t e;
    bin = 1;
    in_valid = 1;
    out_ready = 1;
    for (int c = 0; c < 80 && got < 3; c++) begin
      acc = in_ready && in_valid;
      if (acc) exp_q.push_back(model(bin, 4));
      if (out_valid) begin
        e = exp_q.pop_front();
        checks++;
        if (bcd !== e.bcd || bcd !== 16'(got + 1)) begin
          errors++;
          $display("FAIL b2b_value: got bcd=%h want %h", bcd, e.bcd);
        end
        if (got > 0) begin
          checks++;
          if (c - last != 14) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d want 14", c - last);
          end
        end
        last = c;
        got++;
      end
      @(posedge clk); #1;
      if (acc) begin
        k++;
        bin = 12'(k + 1);
        if (k == 3) in_valid = 0;
      end
    end
    out_ready = 0;
    in_valid = 0;
    checks++;
    if (got != 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d results want 3", got);
    end
  endtask
  task automatic test_digits3;
    logic [11:0] vals [2] = '{12'd1000, 12'd999};
    exp_t e;
    int n;
    for (int i = 0; i < 2; i++) begin
      e = model(vals[i], 3);
      b3 = vals[i];
      iv3 = 1;
      @(posedge clk); #1;
      iv3 = 0;
      n = 0;
      while (!ov3 && n < 40) begin
        @(posedge clk); #1; n++;
      end
      checks++;
      if (!ov3 || bcd3 !== e.bcd[11:0] || ovf3 !== e.ovf || bcd3 !== 12'h999 || ovf3 !== (i == 0)) begin
        errors++;
        $display("FAIL digits3: got vld=%b bcd=%h ovf=%b want 1 %h %b", ov3, bcd3, ovf3, e.bcd[11:0], e.ovf);
      end
      or3 = 1;
      @(posedge clk); #1;
      or3 = 0;
    end
  endtask
  initial begin
    test_reset();
    test_convert();
    test_latch();
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
    test_digits3();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bin_bcd_conv.md
BIN_BCD_CONV -- requirements
Module: bin_bcd_conv

Interface
REQ-001 SHALL have parameter BIN_W, default 12, binary input width (legal 4..32).
REQ-002 SHALL have parameter DIGITS, default 4, BCD output digit count (legal 1..10).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous active-high reset.
REQ-005 SHALL have port in_valid  input  1  bin holds a value to convert.
REQ-006 SHALL have port in_ready  output  1  block accepts a new value; high only in IDLE.
REQ-007 SHALL have port bin  input  BIN_W  value to convert.
REQ-008 SHALL have port out_valid  output  1  bcd/ovf/neg hold a finished result; high only in DONE.
REQ-009 SHALL have port out_ready  input  1  consumer takes the result.
REQ-010 SHALL have port bcd  output  4*DIGITS  packed BCD, digit 0 (ones) in bits 3:0.
REQ-011 SHALL have port ovf  output  1  value exceeded 10^DIGITS-1.
REQ-012 SHALL have port neg  output  1  input was negative (signed build only; else 0).

Function
REQ-013 SHALL implement states IDLE, CONV, DONE; IDLE->CONV on edge with in_valid&&in_ready; CONV->DONE after exactly BIN_W CONV edges; DONE->IDLE on edge with out_valid&&out_ready.
REQ-014 SHALL latch bin (or its magnitude, REQ-026) at the accept edge and clear the BCD working register and bit counter; later changes on bin SHALL not affect the conversion.
REQ-015 SHALL, on each CONV edge, add 3 to every working digit >=5, then shift left one bit, inserting the next latched bit MSB-first; one bit per cycle.
REQ-016 SHALL raise out_valid exactly BIN_W cycles after the accept edge; minimum spacing between accepts is BIN_W+2 cycles.
REQ-017 SHALL set ovf if any 1 is shifted out of the top digit during the conversion; ovf is sticky for that conversion only.
REQ-018 SHALL, when ovf=1, present bcd saturated to all digits 9; otherwise the exact BCD value.
REQ-019 SHALL drive in_ready combinationally from state (IDLE only); in_valid in CONV/DONE is ignored, not queued.
REQ-020 SHALL hold bcd, ovf, neg stable from DONE entry until the next accept edge, including indefinitely while out_ready=0.
REQ-021 SHALL allow out_ready high before DONE; it has effect only in DONE (single-cycle out_valid pulse if already high).
REQ-022 SHALL size the bit counter clog2(BIN_W+1) and never wrap during a conversion.

Reset
REQ-023 SHALL, on reset at any clock edge (including mid-CONV or in DONE), enter IDLE and clear bcd, ovf, neg, out_valid, counter and latched value; pending result is discarded.
REQ-024 SHALL have in_ready=1 in the first cycle after reset deasserts.
REQ-025 SHALL give reset priority over all handshakes on the same edge.

Configuration
REQ-026 SHALL, with macro BIN_BCD_SIGNED_EN defined, treat bin as two's complement: latch |bin| and set neg=bin[BIN_W-1]; -2^(BIN_W-1) converts as magnitude 2^(BIN_W-1).
REQ-027 SHALL, without BIN_BCD_SIGNED_EN, treat bin as unsigned and drive neg=0; port list unchanged.

Verification
REQ-028 Defaults, unsigned: bin=4095 accepted -> out_valid 12 cycles later, bcd=0x4095, ovf=0; bin=0 -> bcd=0x0000.
REQ-029 DIGITS=3, unsigned: bin=1000 -> ovf=1, bcd=0x999; bin=999 -> ovf=0, bcd=0x999.
REQ-030 Backpressure: out_ready low 5 cycles in DONE -> bcd held, in_ready=0, in_valid with bin=7 not accepted; out_ready high -> IDLE, next accept converts 7 -> 0x0007.
REQ-031 Reset asserted at 6th CONV cycle of bin=1234 -> next cycle IDLE, out_valid=0, bcd=0; new bin=56 converts to 0x0056.
REQ-032 BIN_BCD_SIGNED_EN: bin=12'hFFF -> bcd=0x0001, neg=1; bin=12'h800 -> bcd=0x2048, neg=1; without macro bin=12'hFFF -> bcd=0x4095, neg=0.
REQ-033 Back-to-back: in_valid and out_ready held high, values 1,2,3 -> three results 0x0001,0x0002,0x0003 spaced 14 cycles apart.
